comparator_4bit_reg: RTL and testbench
======================================

// Module: comparator_4bit_reg
// PURPOSE
//   4-bit magnitude comparator with registered, one-hot result flags.
//   Compares operand A = {a3,a2,a1,a0} against B = {b3,b2,b1,b0} and reports greater / equal / less.
//   Used as a leaf block wherever a clocked A-vs-B decision is needed.
//   One clock domain; all outputs are flops.
// PARAMETERS
//   none (width fixed at 4 bits; a3/b3 = MSB, a0/b0 = LSB)
// PORTS
//   clk  input  1  rising-edge clock, single domain
//   rst  input  1  asynchronous reset, active-high
//   a3   input  1  operand A bit 3 (MSB)
//   a2   input  1  operand A bit 2
//   a1   input  1  operand A bit 1
//   a0   input  1  operand A bit 0 (LSB)
//   b3   input  1  operand B bit 3 (MSB)
//   b2   input  1  operand B bit 2
//   b1   input  1  operand B bit 1
//   b0   input  1  operand B bit 0 (LSB)
//   x    output 1  A > B
//   y    output 1  A == B
//   z    output 1  A < B
// BEHAVIOUR
//   - Reset: rst high clears x, y and z to 0 immediately, with no clock edge needed. They hold 0 while rst is high.
//   - Normal operation: on each rising clk edge with rst low, sample A and B and register the result:
//     x <= (A>B), y <= (A==B), z <= (A<B).
//   - Latency: exactly 1 cycle. There is no enable and no handshake; the block samples every cycle.
//   - One-hot: after the first post-reset edge, exactly one of x/y/z is 1.
//     All-zero occurs only during or after reset and before that first edge.
//   - Comparison: decide at the MSB first. If a3 != b3, the MSB decides. Otherwise fall through
//     bit-by-bit to a0. If all bits are equal, y=1.
//   - Boundaries:
//     0000 vs 0000 -> y.  1111 vs 1111 -> y.
//     1111 vs 0000 -> x (unsigned).  0000 vs 1111 -> z (unsigned).
//   - Reset asserted mid-stream: outputs drop to 0 asynchronously.
//     After rst deasserts, the first valid result appears at the next rising edge.
//   - Inputs changing between edges have no effect on outputs (no combinational path from inputs to outputs).
// CONFIGURATION
//   CMP_SIGNED_EN
//     - Defined: A and B are 4-bit two's complement, range -8..+7; a3/b3 are sign bits.
//     - Not defined (default): A and B are unsigned, range 0..15.
//     - Reset, latency and the one-hot rule are identical in both modes.
// TESTING
//   - Reset: hold rst=1 and apply any A/B -> x=y=z=0 with no clock edge needed.
//     Release rst, clock once with A=0000, B=0000 -> y=1, x=z=0.
//   - Unsigned directed, one edge per vector:
//     1001/0110 -> x=1;  0101/1010 -> z=1;  1111/1111 -> y=1;  0001/0010 -> z=1;  1010/0101 -> x=1.
//   - Latency: change A/B between edges -> outputs do not move until the next rising clk edge.
//   - Mid-run reset: while x=1, pulse rst between edges -> x/y/z=0 at once.
//     Next edge with A=0011, B=0011 -> y=1.
//   - Exhaustive: all 256 A/B pairs -> exactly one flag set, matching a reference compare one cycle later.
//   - CMP_SIGNED_EN: 1001/0110 (-7 vs 6) -> z=1;  0101/1010 (5 vs -6) -> x=1;
//     1000/0111 (-8 vs 7) -> z=1;  1111/1111 -> y=1.

Source files
------------

// File: rtl/comparator_4bit_reg.sv
// rtl/comparator_4bit_reg.sv - 4-bit magnitude comparator with registered one-hot gt/eq/lt flags
// Optional CMP_SIGNED_EN: treat operands as two's complement instead of unsigned.
module comparator_4bit_reg (
    input  logic clk,
    input  logic rst,
    input  logic a3,
    input  logic a2,
    input  logic a1,
    input  logic a0,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    output logic x,
    output logic y,
    output logic z
);

    logic [3:0] a;
    logic [3:0] b;
    logic       gt;
    logic       eq;
    logic       lt;

    assign a = {a3, a2, a1, a0};
    assign b = {b3, b2, b1, b0};

    // MSB-first priority: the highest differing bit decides.
    always_comb begin
        gt = 1'b0;
        eq = 1'b0;
        lt = 1'b0;
        if (a[3] != b[3]) begin
`ifdef CMP_SIGNED_EN
            // Differing sign bits: the operand with the sign bit set is the smaller one.
            gt = b[3];
            lt = a[3];
`else
            gt = a[3];
            lt = b[3];
`endif
        end else if (a[2] != b[2]) begin
            gt = a[2];
            lt = b[2];
        end else if (a[1] != b[1]) begin
            gt = a[1];
            lt = b[1];
        end else if (a[0] != b[0]) begin
            gt = a[0];
            lt = b[0];
        end else begin
            eq = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= 1'b0;
            y <= 1'b0;
            z <= 1'b0;
        end else begin
            x <= gt;
            y <= eq;
            z <= lt;
        end
    end

endmodule

// File: tb/tb_comparator_4bit_reg.sv
// tb/tb_comparator_4bit_reg.sv - randomized and directed bench for comparator_4bit_reg
module tb_comparator_4bit_reg;

    logic clk = 1'b0;
    logic rst;
    logic a3, a2, a1, a0;
    logic b3, b2, b1, b0;
    logic x, y, z;

    int total = 0;
    int bad   = 0;

    comparator_4bit_reg dut (
        .clk(clk), .rst(rst),
        .a3(a3), .a2(a2), .a1(a1), .a0(a0),
        .b3(b3), .b2(b2), .b1(b1), .b0(b0),
        .x(x), .y(y), .z(z)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got xyz=%b expected xyz=%b", tag, got, exp);
        end
    endtask

    function automatic int to_num(input logic [3:0] v);
`ifdef CMP_SIGNED_EN
        return v[3] ? int'(v) - 16 : int'(v);
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [3:0] av, input logic [3:0] bv);
        int na;
        int nb;
        na = to_num(av);
        nb = to_num(bv);
        if (na > nb) return 3'b100;
        if (na == nb) return 3'b010;
        return 3'b001;
    endfunction

    task automatic drive(input logic [3:0] av, input logic [3:0] bv);
        {a3, a2, a1, a0} = av;
        {b3, b2, b1, b0} = bv;
    endtask

    task automatic step(input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        drive(av, bv);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] dir_a   [9] = '{4'b1001, 4'b0101, 4'b1111, 4'b0001, 4'b1010,
                                4'b0000, 4'b1111, 4'b0000, 4'b1000};
    logic [3:0] dir_b   [9] = '{4'b0110, 4'b1010, 4'b1111, 4'b0010, 4'b0101,
                                4'b0000, 4'b0000, 4'b1111, 4'b0111};
`ifdef CMP_SIGNED_EN
    logic [2:0] dir_exp [9] = '{3'b001, 3'b100, 3'b010, 3'b001, 3'b001,
                                3'b010, 3'b001, 3'b100, 3'b001};
`else
    logic [2:0] dir_exp [9] = '{3'b100, 3'b001, 3'b010, 3'b001, 3'b100,
                                3'b010, 3'b100, 3'b001, 3'b100};
`endif

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] held;

        rst = 1'b1;
        drive(4'b1010, 4'b0101);
        #2;
        check_eq("reset_async", {x, y, z}, 3'b000);
        @(posedge clk);
        #1;
        check_eq("reset_hold", {x, y, z}, 3'b000);

        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 4'b0000);
        #1;
        check_eq("pre_first_edge", {x, y, z}, 3'b000);
        @(posedge clk);
        #1;
        check_eq("first_edge", {x, y, z}, 3'b010);

        for (int i = 0; i < 9; i++) begin
            step(dir_a[i], dir_b[i]);
            check_eq($sformatf("directed_%0d", i), {x, y, z}, dir_exp[i]);
        end

        // Latency: inputs changing between edges must not reach the outputs.
        step(4'b0111, 4'b0000);
        held = ref_cmp(4'b0111, 4'b0000);
        check_eq("lat_before", {x, y, z}, held);
        #2;
        drive(4'b0000, 4'b0111);
        #1;
        check_eq("lat_hold", {x, y, z}, held);
        @(posedge clk);
        #1;
        check_eq("lat_after", {x, y, z}, ref_cmp(4'b0000, 4'b0111));

        // Mid-run reset while x is set.
        step(4'b0111, 4'b0000);
        check_eq("midrst_x", {x, y, z}, 3'b100);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_clear", {x, y, z}, 3'b000);
        drive(4'b0011, 4'b0011);
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_wait", {x, y, z}, 3'b000);
        @(posedge clk);
        #1;
        check_eq("midrst_recover", {x, y, z}, 3'b010);

        for (int i = 0; i < 256; i++) begin
            ra = i[7:4];
            rb = i[3:0];
            step(ra, rb);
            check_eq($sformatf("exh_%h_%h", ra, rb), {x, y, z}, ref_cmp(ra, rb));
        end

        for (int i = 0; i < 200; i++) begin
            ra = 4'($urandom_range(15, 0));
            rb = 4'($urandom_range(15, 0));
            step(ra, rb);
            check_eq($sformatf("rnd_%h_%h", ra, rb), {x, y, z}, ref_cmp(ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
